// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: JTAG TAP in the system clock domain, stepping on oversampled TCK edges.
// Provides IDCODE/BYPASS internally and N user DR channels that shift through the strobes.
module jtag_tap_oversampled #(
    parameter int                            IrLength    = 5,
    parameter logic [31:0]                   IdcodeValue = 32'h00000001,
    parameter int                            NumUserDr   = 2,
    parameter logic [NumUserDr*IrLength-1:0] UserIrCodes = {5'h11, 5'h10},
    parameter int                            SyncStages  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tck_i,
    input  logic                 tms_i,
    input  logic                 tdi_i,
    output logic                 tdo_o,
    output logic                 tdo_oe_o,
    output logic [IrLength-1:0]  ir_o,
    output logic                 tap_reset_o,
    output logic [NumUserDr-1:0] user_select_o,
    output logic                 capture_o,
    output logic                 shift_o,
    output logic                 update_o,
    output logic                 tdi_o,
    input  logic [NumUserDr-1:0] user_tdo_i
);
    typedef enum logic [3:0] {
        TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr,
        UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
    } state_t;

    localparam logic [IrLength-1:0] IrIdcode = IrLength'(1);

    state_t                r_state, w_next;
    logic [SyncStages-1:0] r_tck_sync, r_tms_sync, r_tdi_sync;
    logic                  r_tck_prev;
    logic                  w_tck_s, w_tms_s, w_tdi_s, w_rise, w_fall;
    logic [IrLength-1:0]   r_ir, r_ir_shift;
    logic [31:0]           r_idcode;
    logic                  r_bypass, r_tdo, r_tdo_oe;
    logic [NumUserDr-1:0]  w_user_sel;
    logic                  w_sel_id, w_sel_user, w_dr_tdo;

    // tms/tdi come from the same stage as tck so they are aligned with the detected edge
    assign w_tck_s    = r_tck_sync[SyncStages-1];
    assign w_tms_s    = r_tms_sync[SyncStages-1];
    assign w_tdi_s    = r_tdi_sync[SyncStages-1];
    assign w_rise     = w_tck_s & ~r_tck_prev;
    assign w_fall     = ~w_tck_s & r_tck_prev;
    assign w_sel_id   = r_ir == IrIdcode;
    assign w_sel_user = |w_user_sel;
    assign w_dr_tdo   = w_sel_id ? r_idcode[0] : w_sel_user ? |(user_tdo_i & w_user_sel) : r_bypass;

    always_comb begin
        w_user_sel = '0;
        for (int k = 0; k < NumUserDr; k++)
            w_user_sel[k] = r_ir == UserIrCodes[k*IrLength +: IrLength];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TestLogicReset: w_next = w_tms_s ? TestLogicReset : RunTestIdle;
            RunTestIdle:    w_next = w_tms_s ? SelectDrScan : RunTestIdle;
            SelectDrScan:   w_next = w_tms_s ? SelectIrScan : CaptureDr;
            CaptureDr:      w_next = w_tms_s ? Exit1Dr : ShiftDr;
            ShiftDr:        w_next = w_tms_s ? Exit1Dr : ShiftDr;
            Exit1Dr:        w_next = w_tms_s ? UpdateDr : PauseDr;
            PauseDr:        w_next = w_tms_s ? Exit2Dr : PauseDr;
            Exit2Dr:        w_next = w_tms_s ? UpdateDr : ShiftDr;
            UpdateDr:       w_next = w_tms_s ? SelectDrScan : RunTestIdle;
            SelectIrScan:   w_next = w_tms_s ? TestLogicReset : CaptureIr;
            CaptureIr:      w_next = w_tms_s ? Exit1Ir : ShiftIr;
            ShiftIr:        w_next = w_tms_s ? Exit1Ir : ShiftIr;
            Exit1Ir:        w_next = w_tms_s ? UpdateIr : PauseIr;
            PauseIr:        w_next = w_tms_s ? Exit2Ir : PauseIr;
            Exit2Ir:        w_next = w_tms_s ? UpdateIr : ShiftIr;
            UpdateIr:       w_next = w_tms_s ? SelectDrScan : RunTestIdle;
            default:        w_next = TestLogicReset;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tck_sync <= '0;
            r_tms_sync <= '0;
            r_tdi_sync <= '0;
            r_tck_prev <= 1'b0;
            r_state    <= TestLogicReset;
            r_ir       <= IrIdcode;
            r_ir_shift <= '0;
            r_idcode   <= IdcodeValue;
            r_bypass   <= 1'b0;
            r_tdo      <= 1'b0;
            r_tdo_oe   <= 1'b0;
        end else begin
            r_tck_sync <= {r_tck_sync[SyncStages-2:0], tck_i};
            r_tms_sync <= {r_tms_sync[SyncStages-2:0], tms_i};
            r_tdi_sync <= {r_tdi_sync[SyncStages-2:0], tdi_i};
            r_tck_prev <= w_tck_s;
            if (w_rise) begin
                r_state <= w_next;
                if (r_state == CaptureIr) r_ir_shift <= IrIdcode;
                if (r_state == ShiftIr) r_ir_shift <= {w_tdi_s, r_ir_shift[IrLength-1:1]};
                if (r_state == UpdateIr) r_ir <= r_ir_shift;
                if (w_sel_id && r_state == CaptureDr) r_idcode <= IdcodeValue;
                if (w_sel_id && r_state == ShiftDr) r_idcode <= {w_tdi_s, r_idcode[31:1]};
                if (!w_sel_id && !w_sel_user && r_state == CaptureDr) r_bypass <= 1'b0;
                if (!w_sel_id && !w_sel_user && r_state == ShiftDr) r_bypass <= w_tdi_s;
            end
            if (r_state == TestLogicReset) r_ir <= IrIdcode;
            if (w_fall) begin
                r_tdo    <= r_state == ShiftIr ? r_ir_shift[0] : w_dr_tdo;
                r_tdo_oe <= r_state == ShiftIr || r_state == ShiftDr;
            end
        end
    end

    assign tdo_o         = r_tdo;
    assign tdo_oe_o      = r_tdo_oe;
    assign ir_o          = r_ir;
    assign tap_reset_o   = r_state == TestLogicReset;
    assign user_select_o = w_user_sel;
    assign capture_o     = w_rise && r_state == CaptureDr;
    assign shift_o       = w_rise && r_state == ShiftDr;
    assign update_o      = w_rise && r_state == UpdateDr;
    assign tdi_o         = w_tdi_s;
endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: directed scans through the oversampled TAP with a bench-side user DR.
module tb_jtag_tap_oversampled;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tck_pad = 1'b0, tms_pad = 1'b1, tdi_pad = 1'b0;
    logic       tdo, tdo_oe, tap_reset, capture, shift, update, tdi_s;
    logic [4:0] ir;
    logic [1:0] user_sel, user_tdo;
    logic [40:0] r_user_dr = '0;
    int         total = 0, bad = 0;
    int         n_cap = 0, n_shift = 0, n_upd = 0;

    localparam logic [40:0] UserPat = 41'h0A5_C3F0_0F1;
    localparam logic [40:0] UserIn  = 41'h135_79BD_F02;

    jtag_tap_oversampled dut (
        .clk_i(clk), .rst_i(rst), .tck_i(tck_pad), .tms_i(tms_pad), .tdi_i(tdi_pad),
        .tdo_o(tdo), .tdo_oe_o(tdo_oe), .ir_o(ir), .tap_reset_o(tap_reset),
        .user_select_o(user_sel), .capture_o(capture), .shift_o(shift), .update_o(update),
        .tdi_o(tdi_s), .user_tdo_i(user_tdo)
    );

    always #5 clk = ~clk;

    // user channel 0 is a real 41-bit DR; channel 1 drives the inverse so a wrong select shows up
    assign user_tdo = {~r_user_dr[0], r_user_dr[0]};
    always @(posedge clk)
        if (shift) r_user_dr <= {tdi_s, r_user_dr[40:1]};
        else if (capture) r_user_dr <= UserPat;

    always @(negedge clk) begin
        if (capture) n_cap++;
        if (shift) n_shift++;
        if (update) n_upd++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // tdo/oe are sampled just before the rise, i.e. what the host would capture on that edge
    task automatic tck_cyc(input logic tms, input logic tdi, output logic t, output logic oe);
        tms_pad = tms;
        tdi_pad = tdi;
        repeat (2) @(posedge clk);
        #1;
        t  = tdo;
        oe = tdo_oe;
        tck_pad = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tck_pad = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic step(input logic tms);
        logic t, oe;
        tck_cyc(tms, 1'b0, t, oe);
    endtask

    task automatic dr_scan(input string tag, input int n, input logic [63:0] din, output logic [63:0] dout);
        logic t, oe, oe_all;
        dout   = '0;
        oe_all = 1'b1;
        step(1'b1);
        step(1'b0);
        tck_cyc(1'b0, 1'b0, t, oe);
        check({tag, "_oe_capture"}, 64'(oe), 64'd0);
        for (int i = 0; i < n; i++) begin
            tck_cyc(i == n - 1, din[i], t, oe);
            dout[i] = t;
            oe_all &= oe;
        end
        check({tag, "_oe_shift"}, 64'(oe_all), 64'd1);
        tck_cyc(1'b1, 1'b0, t, oe);
        check({tag, "_oe_exit"}, 64'(oe), 64'd0);
        step(1'b0);
    endtask

    task automatic ir_scan(input logic [4:0] din, output logic [4:0] dout);
        logic t, oe;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 5; i++) begin
            tck_cyc(i == 4, din[i], t, oe);
            dout[i] = t;
        end
        step(1'b1);
        step(1'b0);
    endtask

    initial begin
        logic [63:0] dout;
        logic [4:0]  irout;
        int          c0, s0, u0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_oe", 64'(tdo_oe), 64'd0);
        check("rst_ir", 64'(ir), 64'd1);
        check("rst_tlr", 64'(tap_reset), 64'd1);
        check("rst_sel", 64'(user_sel), 64'd0);
        check("rst_strobes", 64'({capture, shift, update}), 64'd0);
        rst = 1'b0;
        repeat (5) step(1'b1);
        check("tlr_hold", 64'(tap_reset), 64'd1);
        step(1'b0);
        check("rti_tlr", 64'(tap_reset), 64'd0);

        dr_scan("idcode", 32, 64'hDEAD_BEEF, dout);
        check("idcode_data", dout, 64'h0000_0001);

        ir_scan(5'h11, irout);
        check("ir_capture", 64'(irout), 64'h01);
        check("ir_11", 64'(ir), 64'h11);
        check("sel_11", 64'(user_sel), 64'h2);

        ir_scan(5'h10, irout);
        check("sel_10", 64'(user_sel), 64'h1);
        c0 = n_cap; s0 = n_shift; u0 = n_upd;
        dr_scan("user0", 41, 64'(UserIn), dout);
        check("user0_tdo", dout, 64'(UserPat));
        check("user0_cap", 64'(n_cap - c0), 64'd1);
        check("user0_shift", 64'(n_shift - s0), 64'd41);
        check("user0_upd", 64'(n_upd - u0), 64'd1);
        check("user0_dr", 64'(r_user_dr), 64'(UserIn));

        ir_scan(5'h07, irout);
        check("sel_07", 64'(user_sel), 64'h0);
        dr_scan("bypass", 9, 64'h0A5, dout);
        check("bypass_data", dout, 64'h14A);

        ir_scan(5'h11, irout);
        check("ir_11b", 64'(ir), 64'h11);
        repeat (5) step(1'b1);
        check("tms_rst_tlr", 64'(tap_reset), 64'd1);
        check("tms_rst_ir", 64'(ir), 64'd1);
        check("tms_rst_sel", 64'(user_sel), 64'd0);

        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 10; i++) begin
            logic t, oe;
            tck_cyc(1'b0, 1'b1, t, oe);
        end
        check("mid_oe_pre", 64'(tdo_oe), 64'd1);
        u0 = n_upd;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_oe", 64'(tdo_oe), 64'd0);
        check("mid_rst_tlr", 64'(tap_reset), 64'd1);
        check("mid_rst_ir", 64'(ir), 64'd1);
        check("mid_rst_tdo", 64'(tdo), 64'd0);
        rst = 1'b0;
        step(1'b1);
        step(1'b0);
        check("mid_rst_no_upd", 64'(n_upd - u0), 64'd0);
        dr_scan("idcode2", 32, 64'h0, dout);
        check("idcode2_data", dout, 64'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
